// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared state encoding and width helpers for bbox_multi_scan
// Contents: FSM state constants and enum type, width functions for address,
// x, y and pixel-count fields (each clamped to at least one bit).
package bbox_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SCAN  = ST_SCAN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int aw_of(input int w, input int h);
    return clog2_min1(w * h);
  endfunction

  function automatic int xw_of(input int w);
    return clog2_min1(w);
  endfunction

  function automatic int yw_of(input int h);
    return clog2_min1(h);
  endfunction

  function automatic int cw_of(input int w, input int h);
    return clog2_min1(w * h + 1);
  endfunction

endpackage

// File: rtl/bbox_accum.sv
// rtl/bbox_accum.sv - per-channel bounding-box accumulator (min/max/hit, optional count)
// Ports: clk_i, reset_i (sync, active high), clr_i (clear for new scan),
// pix_i (matching pixel this cycle), x_i/y_i (pixel coordinates),
// *_d_o (next-state values, so the caller can latch results in the same
// cycle the final pixel is folded in). Macro BBOX_COUNT_EN adds cnt_d_o.
module bbox_accum
  import bbox_pkg::*;
#(
  parameter int XW = 7,
  parameter int YW = 7,
  parameter int CW = 14
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          pix_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
`ifdef BBOX_COUNT_EN
  output logic [CW-1:0] cnt_d_o,
`endif
  output logic          hit_d_o,
  output logic [XW-1:0] xmin_d_o,
  output logic [XW-1:0] xmax_d_o,
  output logic [YW-1:0] ymin_d_o,
  output logic [YW-1:0] ymax_d_o
);

  logic          hit_q;
  logic [XW-1:0] xmin_q, xmax_q;
  logic [YW-1:0] ymin_q, ymax_q;

  always_comb begin
    hit_d_o  = hit_q;
    xmin_d_o = xmin_q;
    xmax_d_o = xmax_q;
    ymin_d_o = ymin_q;
    ymax_d_o = ymax_q;
    if (clr_i) begin
      hit_d_o  = 1'b0;
      xmin_d_o = '0;
      xmax_d_o = '0;
      ymin_d_o = '0;
      ymax_d_o = '0;
    end else if (pix_i) begin
      if (!hit_q) begin
        // First hit seeds all four bounds; zeroed bounds are not usable as a min.
        hit_d_o  = 1'b1;
        xmin_d_o = x_i;
        xmax_d_o = x_i;
        ymin_d_o = y_i;
        ymax_d_o = y_i;
      end else begin
        if (x_i < xmin_q) xmin_d_o = x_i;
        if (x_i > xmax_q) xmax_d_o = x_i;
        if (y_i < ymin_q) ymin_d_o = y_i;
        if (y_i > ymax_q) ymax_d_o = y_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_q  <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
    end else begin
      hit_q  <= hit_d_o;
      xmin_q <= xmin_d_o;
      xmax_q <= xmax_d_o;
      ymin_q <= ymin_d_o;
      ymax_q <= ymax_d_o;
    end
  end

`ifdef BBOX_COUNT_EN
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d_o = cnt_q;
    if (clr_i)      cnt_d_o = '0;
    else if (pix_i) cnt_d_o = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d_o;
  end
`endif

endmodule

// File: rtl/bbox_multi_scan.sv
// rtl/bbox_multi_scan.sv - raster scan of a label image producing per-channel bounding boxes
// Ports: CLOCK_50, reset (sync, active high), start (scan request),
// busy/done (status, done sticky), mem_addr/mem_rd/mem_rdata (pixel read
// port, data one cycle after mem_rd), x_min/x_max/y_min/y_max/bbox_valid
// (per-channel results, updated only when a scan completes).
// Macro BBOX_COUNT_EN adds pix_count (matching pixels per channel).
module bbox_multi_scan
  import bbox_pkg::*;
#(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int PIX_W  = 8,
  parameter int NUM_CH = 4
) (
  input  logic                                       CLOCK_50,
  input  logic                                       reset,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic [aw_of(IMG_W, IMG_H)-1:0]             mem_addr,
  output logic                                       mem_rd,
  input  logic [PIX_W-1:0]                           mem_rdata,
  output logic [NUM_CH-1:0][xw_of(IMG_W)-1:0]        x_min,
  output logic [NUM_CH-1:0][xw_of(IMG_W)-1:0]        x_max,
  output logic [NUM_CH-1:0][yw_of(IMG_H)-1:0]        y_min,
  output logic [NUM_CH-1:0][yw_of(IMG_H)-1:0]        y_max,
`ifdef BBOX_COUNT_EN
  output logic [NUM_CH-1:0][cw_of(IMG_W, IMG_H)-1:0] pix_count,
`endif
  output logic [NUM_CH-1:0]                          bbox_valid
);

  localparam int AW   = aw_of(IMG_W, IMG_H);
  localparam int XW   = xw_of(IMG_W);
  localparam int YW   = yw_of(IMG_H);
  localparam int CW   = cw_of(IMG_W, IMG_H);
  localparam int NPIX = IMG_W * IMG_H;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d, xd1_q;
  logic [YW-1:0] y_q, y_d, yd1_q;
  logic          rd_vld_q;
  logic          clr, latch;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    clr     = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
          clr     = 1'b1;
        end
      end
      SCAN: begin
        if (addr_q == AW'(NPIX - 1)) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
          // Coordinates come from wrap counters instead of dividing the address.
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        latch   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xd1_q    <= '0;
      yd1_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      // One-cycle delay lines up the coordinates with mem_rdata.
      xd1_q    <= x_q;
      yd1_q    <= y_q;
      rd_vld_q <= mem_rd;
    end
  end

  assign mem_rd   = (state_q == SCAN);
  assign mem_addr = addr_q;
  assign busy     = (state_q == SCAN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  logic [NUM_CH-1:0]         hit_d;
  logic [NUM_CH-1:0][XW-1:0] xmin_d, xmax_d;
  logic [NUM_CH-1:0][YW-1:0] ymin_d, ymax_d;
`ifdef BBOX_COUNT_EN
  logic [NUM_CH-1:0][CW-1:0] cnt_d;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bbox_accum #(.XW(XW), .YW(YW), .CW(CW)) u_accum (
      .clk_i    (CLOCK_50),
      .reset_i  (reset),
      .clr_i    (clr),
      .pix_i    (rd_vld_q && (mem_rdata == PIX_W'(c + 1))),
      .x_i      (xd1_q),
      .y_i      (yd1_q),
`ifdef BBOX_COUNT_EN
      .cnt_d_o  (cnt_d[c]),
`endif
      .hit_d_o  (hit_d[c]),
      .xmin_d_o (xmin_d[c]),
      .xmax_d_o (xmax_d[c]),
      .ymin_d_o (ymin_d[c]),
      .ymax_d_o (ymax_d[c])
    );
  end

  // Results are taken from next-state values so the last pixel, consumed on
  // the DRAIN->DONE edge, is included in the same cycle done rises.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      bbox_valid <= '0;
`ifdef BBOX_COUNT_EN
      pix_count  <= '0;
`endif
    end else if (latch) begin
      x_min      <= xmin_d;
      x_max      <= xmax_d;
      y_min      <= ymin_d;
      y_max      <= ymax_d;
      bbox_valid <= hit_d;
`ifdef BBOX_COUNT_EN
      pix_count  <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bbox_multi_scan.sv
// tb/tb_bbox_multi_scan.sv - directed self-checking bench for bbox_multi_scan
module tb_bbox_multi_scan;

  localparam int W = 100;
  localparam int H = 100;
  localparam int N = W * H;

  logic            clk = 1'b0;
  logic            reset, start;
  logic            busy, done, mem_rd;
  logic [13:0]     mem_addr;
  logic [7:0]      mem_rdata;
  logic [3:0][6:0] x_min, x_max, y_min, y_max;
  logic [3:0]      bbox_valid;
`ifdef BBOX_COUNT_EN
  logic [3:0][13:0] pix_count;
`endif

  logic [7:0] mem [0:N-1];
  int n_tot = 0;
  int n_bad = 0;
  int cyc;

  always #10 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  bbox_multi_scan dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
`ifdef BBOX_COUNT_EN
    .pix_count  (pix_count),
`endif
    .bbox_valid (bbox_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) mem[i] = 8'd0;
  endtask

  task automatic put(input int x, input int y, input int v);
    mem[y * W + x] = 8'(v);
  endtask

  task automatic put_rect();
    for (int y = 29; y <= 65; y++)
      for (int x = 28; x <= 79; x++) put(x, y, 2);
    put(4, 16, 3);
    put(50, 90, 5);
    put(60, 5, 255);
  endtask

  task automatic check_ch(input int c, input logic v, input int x0, input int y0,
                          input int x1, input int y1);
    chk($sformatf("valid%0d", c), 32'(bbox_valid[c]), 32'(v));
    chk($sformatf("x_min%0d", c), 32'(x_min[c]), x0);
    chk($sformatf("y_min%0d", c), 32'(y_min[c]), y0);
    chk($sformatf("x_max%0d", c), 32'(x_max[c]), x1);
    chk($sformatf("y_max%0d", c), 32'(y_max[c]), y1);
  endtask

  // Runs one scan. Optionally pulses start again at cycle start_at, asserts
  // reset at cycle reset_at (cyc returned as -1), or checks at cycle 100 that
  // the previous results are still on the outputs.
  task automatic run_scan(input int start_at, input int reset_at, input bit hold_en,
                          input logic [3:0] hold_v, input int hold_x1, output int cyc_o);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc_o = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_drops", 32'(done), 32'd0);
    while (!done && cyc_o < 20000) begin
      start = (cyc_o == start_at);
      if (cyc_o == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(bbox_valid), 32'd0);
        chk("rst_x_max0", 32'(x_max[0]), 32'd0);
        chk("rst_y_max0", 32'(y_max[0]), 32'd0);
        cyc_o = -1;
        return;
      end
      if (hold_en && cyc_o == 100) begin
        chk("hold_valid", 32'(bbox_valid), 32'(hold_v));
        chk("hold_x_min1", 32'(x_min[1]), hold_x1);
        chk("scan_mem_rd", 32'(mem_rd), 32'd1);
      end
      @(negedge clk);
      cyc_o++;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_img();
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_valid", 32'(bbox_valid), 32'd0);
    reset = 1'b0;

    // single pixel at the far corner
    put(99, 99, 1);
    run_scan(-1, -1, 1'b0, 4'd0, 0, cyc);
    chk("latency_corner", cyc, N + 2);
    check_ch(0, 1'b1, 99, 99, 99, 99);
    for (int c = 1; c < 4; c++) check_ch(c, 1'b0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("done_sticky", 32'(done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_mem_rd", 32'(mem_rd), 32'd0);
    chk("done_addr_held", 32'(mem_addr), N - 1);

    // single pixel at the origin, started from DONE
    clear_img();
    put(0, 0, 1);
    run_scan(-1, -1, 1'b0, 4'd0, 0, cyc);
    chk("latency_origin", cyc, N + 2);
    check_ch(0, 1'b1, 0, 0, 0, 0);

    // rectangle of label 2, label 3 dot, out-of-range labels ignored
    clear_img();
    put_rect();
    run_scan(-1, -1, 1'b0, 4'd0, 0, cyc);
    chk("latency_rect", cyc, N + 2);
    check_ch(0, 1'b0, 0, 0, 0, 0);
    check_ch(1, 1'b1, 28, 29, 79, 65);
    check_ch(2, 1'b1, 4, 16, 4, 16);
    check_ch(3, 1'b0, 0, 0, 0, 0);
`ifdef BBOX_COUNT_EN
    chk("count1", 32'(pix_count[1]), 32'd1924);
    chk("count2", 32'(pix_count[2]), 32'd1);
    chk("count0", 32'(pix_count[0]), 32'd0);
`endif

    // all-zero image with a stray start mid-scan
    clear_img();
    run_scan(50, -1, 1'b0, 4'd0, 0, cyc);
    chk("latency_zero_start50", cyc, N + 2);
    chk("zero_valid", 32'(bbox_valid), 32'd0);
    check_ch(1, 1'b0, 0, 0, 0, 0);

    // back-to-back: rectangle, then a new image; old results held mid-scan
    put_rect();
    run_scan(-1, -1, 1'b0, 4'd0, 0, cyc);
    check_ch(1, 1'b1, 28, 29, 79, 65);
    clear_img();
    put(99, 99, 1);
    put(10, 20, 4);
    run_scan(-1, -1, 1'b1, 4'b0110, 28, cyc);
    chk("latency_b2b", cyc, N + 2);
    check_ch(0, 1'b1, 99, 99, 99, 99);
    check_ch(1, 1'b0, 0, 0, 0, 0);
    check_ch(2, 1'b0, 0, 0, 0, 0);
    check_ch(3, 1'b1, 10, 20, 10, 20);

    // reset mid-scan, then a clean scan
    clear_img();
    put_rect();
    run_scan(-1, 500, 1'b0, 4'd0, 0, cyc);
    chk("reset_aborts", cyc, -1);
    run_scan(-1, -1, 1'b0, 4'd0, 0, cyc);
    chk("latency_after_reset", cyc, N + 2);
    check_ch(1, 1'b1, 28, 29, 79, 65);
    check_ch(2, 1'b1, 4, 16, 4, 16);
    chk("valid_after_reset", 32'(bbox_valid), 32'b0110);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/bbox_multi_scan.md
BBOX_MULTI_SCAN -- requirements
Module: bbox_multi_scan

Interface
REQ-001 SHALL have parameter IMG_W, default 100, meaning image width in pixels (>=1).
REQ-002 SHALL have parameter IMG_H, default 100, meaning image height in pixels (>=1).
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel/label width in bits.
REQ-004 SHALL have parameter NUM_CH, default 4, meaning number of label channels (1..2**PIX_W-1).
REQ-005 SHALL have port CLOCK_50, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle scan request.
REQ-008 SHALL have port busy, output, 1, high from the cycle after an accepted start until done rises.
REQ-009 SHALL have port done, output, 1, sticky completion flag.
REQ-010 SHALL have ports mem_addr, output, AW=$clog2(IMG_W*IMG_H), and mem_rd, output, 1: raster pixel address and read strobe.
REQ-011 SHALL have port mem_rdata, input, PIX_W, pixel data valid exactly one cycle after mem_rd.
REQ-012 SHALL have ports x_min, x_max, output, NUM_CH x XW=$clog2(IMG_W); y_min, y_max, output, NUM_CH x YW=$clog2(IMG_H); bbox_valid, output, NUM_CH: per-channel results.

Function
REQ-013 SHALL classify pixel value v in 1..NUM_CH as channel v-1; value 0 and values >NUM_CH SHALL be ignored.
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE/DONE + start: clear accumulators, mem_addr=0, go SCAN; done drops the same edge.
REQ-016 SCAN: mem_rd=1 every cycle, mem_addr increments 0..IMG_W*IMG_H-1 raster order (x fastest); after issuing last address go DRAIN.
REQ-017 DRAIN: one cycle consuming final read data, then DONE.
REQ-018 x/y SHALL come from wrap counters (x wraps at IMG_W-1, y increments), delayed one cycle to align with mem_rdata; no divider.
REQ-019 Per matching pixel: min/max update per axis; first hit of a channel loads all four coords and sets internal hit flag.
REQ-020 On entry to DONE, accumulator values SHALL be copied to outputs in one cycle; outputs hold previous results throughout SCAN/DRAIN.
REQ-021 Channel with no hits: bbox_valid=0 and its four coords=0.
REQ-022 Latency: done high exactly IMG_W*IMG_H+2 cycles after the start cycle.
REQ-023 start while busy SHALL be ignored; start in DONE restarts.
REQ-024 mem_rd=0 and mem_addr held in IDLE, DRAIN, DONE.

Reset
REQ-025 reset SHALL, at any state including mid-SCAN, force IDLE, busy=0, done=0, mem_rd=0, mem_addr=0, all coords=0, bbox_valid=0, accumulators cleared; reset overrides simultaneous start.

Configuration
REQ-026 With BBOX_COUNT_EN defined, SHALL add output pix_count, NUM_CH x $clog2(IMG_W*IMG_H+1), matching-pixel count per channel, latched with other results, reset 0.
REQ-027 Without BBOX_COUNT_EN, port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package bbox_pkg SHALL hold state enum type and width helper constants/functions for AW, XW, YW.
REQ-029 Per-channel min/max/hit (and count) logic SHALL be sub-module bbox_accum, instantiated NUM_CH times via generate.

Verification
REQ-030 Defaults, single label-1 pixel at (99,99) -> ch0 = 99,99,99,99, valid=1; ch1..3 valid=0, coords 0.
REQ-031 Single label-1 pixel at (0,0) -> ch0 = 0,0,0,0, valid=1.
REQ-032 Filled rectangle label 2, x 28..79, y 29..65, plus label-3 pixel at (4,16) -> ch1 = 28,29,79,65; ch2 = 4,16,4,16; with BBOX_COUNT_EN pix_count[1]=1924, pix_count[2]=1.
REQ-033 All-zero image -> all bbox_valid=0, done exactly 10002 cycles after start.
REQ-034 start pulsed at cycle 50 of scan -> ignored, latency unchanged; reset asserted at cycle 500 -> next cycle IDLE, done=0, outputs 0; fresh start completes correctly.
REQ-035 Back-to-back scans (start in DONE) of two images -> second results replace first only at second done.
